// File: rtl/uart_frame_streamer.sv
// uart_frame_streamer
//   Buffers payload bytes from the analysis pipeline in a FIFO and streams
//   them to a byte-wide UART transmitter as framed packets:
//     SYNC0, SYNC1, payload bytes ..., [XOR checksum], then an idle gap.
//   Each byte uses a trigger/busy handshake: one-cycle trigger pulse, wait
//   for busy to rise, then wait for busy to fall.
//
//   Optional feature macro: UART_FRAME_CHECKSUM_EN
//     defined   -> an 8-bit XOR of the frame payload is sent after the last
//                  payload byte (CSUM state).
//     undefined -> no CSUM state and no accumulator; PAYLOAD goes to GAP.
//
// Parameters
//   FIFO_DEPTH  payload FIFO entries (power of two, >= 2)
//   SYNC0/SYNC1 header bytes
//   GAP_CYCLES  idle cycles after each frame (0 -> GAP lasts one cycle)
//
// Ports
//   clk_in          system clock
//   rst_in          asynchronous active-low reset
//   byte_in         payload byte
//   byte_valid_in   byte_in valid this cycle
//   last_in         byte_in ends its frame (qualified by byte_valid_in)
//   ready_out       FIFO not full
//   tx_byte_out     byte to the UART transmitter
//   tx_trigger_out  one-cycle start pulse to the UART transmitter
//   tx_busy_in      UART transmitter busy
//   overflow_out    sticky: a byte was dropped because the FIFO was full
//   frames_sent_out completed frame count (wraps at 2^16)
module uart_frame_streamer #(
  parameter int unsigned FIFO_DEPTH = 512,
  parameter logic [7:0]  SYNC0      = 8'hA5,
  parameter logic [7:0]  SYNC1      = 8'h5A,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid_in,
  input  logic        last_in,
  output logic        ready_out,
  output logic [7:0]  tx_byte_out,
  output logic        tx_trigger_out,
  input  logic        tx_busy_in,
  output logic        overflow_out,
  output logic [15:0] frames_sent_out
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC_A,
    ST_SYNC_B,
    ST_PAYLOAD,
`ifdef UART_FRAME_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_GAP
  } state_t;

  typedef enum logic [1:0] {
    HS_SEND,
    HS_WAIT_HI,
    HS_WAIT_LO
  } hs_t;

  // FIFO storage: {last, byte}. Pointers carry one extra bit so full and
  // empty are distinguishable; they wrap naturally modulo FIFO_DEPTH.
  logic [8:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [8:0]    w_head;

  state_t        r_state;
  hs_t           r_hs;
  logic          r_trigger;
  logic [7:0]    r_tx_byte;
  logic          r_last;
  logic          r_overflow;
  logic [15:0]   r_frames;
  logic [31:0]   r_gap_cnt;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]    r_csum;
`endif

  logic          w_send_ok;
  logic [7:0]    w_send_byte;
  state_t        w_next_state;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  // The payload entry is copied into tx_byte_out when the trigger is
  // registered and retired from the FIFO during the trigger cycle itself.
  // A write arriving while full in that cycle is accepted into the slot
  // being freed.
  assign w_pop  = r_trigger && (r_state == ST_PAYLOAD);
  assign w_push = byte_valid_in && (!w_full || w_pop);

  assign ready_out       = !w_full;
  assign tx_byte_out     = r_tx_byte;
  assign tx_trigger_out  = r_trigger;
  assign overflow_out    = r_overflow;
  assign frames_sent_out = r_frames;

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {last_in, byte_in};
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (byte_valid_in && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // Byte to launch and successor state for the byte-sending states.
  always_comb begin
    w_send_ok    = 1'b0;
    w_send_byte  = 8'h00;
    w_next_state = r_state;
    unique case (r_state)
      ST_SYNC_A: begin
        w_send_ok    = 1'b1;
        w_send_byte  = SYNC0;
        w_next_state = ST_SYNC_B;
      end
      ST_SYNC_B: begin
        w_send_ok    = 1'b1;
        w_send_byte  = SYNC1;
        w_next_state = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        w_send_ok    = !w_empty;
        w_send_byte  = w_head[7:0];
`ifdef UART_FRAME_CHECKSUM_EN
        w_next_state = r_last ? ST_CSUM : ST_PAYLOAD;
`else
        w_next_state = r_last ? ST_GAP : ST_PAYLOAD;
`endif
      end
`ifdef UART_FRAME_CHECKSUM_EN
      ST_CSUM: begin
        w_send_ok    = 1'b1;
        w_send_byte  = r_csum;
        w_next_state = ST_GAP;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state   <= ST_IDLE;
      r_hs      <= HS_SEND;
      r_trigger <= 1'b0;
      r_tx_byte <= 8'h00;
      r_last    <= 1'b0;
      r_frames  <= 16'd0;
      r_gap_cnt <= 32'd0;
`ifdef UART_FRAME_CHECKSUM_EN
      r_csum    <= 8'h00;
`endif
    end else begin
      r_trigger <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (!w_empty && !tx_busy_in) begin
            r_state <= ST_SYNC_A;
            r_hs    <= HS_SEND;
            r_last  <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
            r_csum  <= 8'h00;
`endif
          end
        end
        ST_GAP: begin
          if (r_gap_cnt + 32'd1 >= GAP_CYCLES) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 32'd1;
          end
        end
        default: begin
          // Shared per-byte handshake for SYNC_A, SYNC_B, PAYLOAD and CSUM.
          unique case (r_hs)
            HS_SEND: begin
              if (w_send_ok) begin
                r_trigger <= 1'b1;
                r_tx_byte <= w_send_byte;
                r_hs      <= HS_WAIT_HI;
                if (r_state == ST_PAYLOAD) begin
                  r_last <= w_head[8];
`ifdef UART_FRAME_CHECKSUM_EN
                  r_csum <= r_csum ^ w_head[7:0];
`endif
                end
              end
            end
            HS_WAIT_HI: begin
              if (tx_busy_in) r_hs <= HS_WAIT_LO;
            end
            HS_WAIT_LO: begin
              if (!tx_busy_in) begin
                r_hs    <= HS_SEND;
                r_state <= w_next_state;
                if (w_next_state == ST_GAP) begin
                  r_frames  <= r_frames + 16'd1;
                  r_gap_cnt <= 32'd0;
                end
              end
            end
            default: r_hs <= HS_SEND;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_streamer.sv
module tb_uart_frame_streamer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid_in = 1'b0;
  logic        last_in = 1'b0;
  logic        ready_out;
  logic [7:0]  tx_byte_out;
  logic        tx_trigger_out;
  logic        tx_busy_in;
  logic        overflow_out;
  logic [15:0] frames_sent_out;

  uart_frame_streamer #(.GAP_CYCLES(4)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .byte_in         (byte_in),
    .byte_valid_in   (byte_valid_in),
    .last_in         (last_in),
    .ready_out       (ready_out),
    .tx_byte_out     (tx_byte_out),
    .tx_trigger_out  (tx_trigger_out),
    .tx_busy_in      (tx_busy_in),
    .overflow_out    (overflow_out),
    .frames_sent_out (frames_sent_out)
  );

  always #5 clk_in = ~clk_in;

  // UART transmitter model: busy for 10 cycles after each trigger.
  int   uart_cnt = 0;
  logic hold_busy = 1'b0;
  always @(posedge clk_in) begin
    if (tx_trigger_out)    uart_cnt <= 10;
    else if (uart_cnt > 0) uart_cnt <= uart_cnt - 1;
  end
  assign tx_busy_in = hold_busy | (uart_cnt != 0);

  int         n_vec  = 0;
  int         n_fail = 0;
  int         n_trig = 0;
  int         idle_run = 0;
  int         idle_before = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_csum = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic exp_header();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_csum = 8'h00;
  endtask

  task automatic exp_data(input logic [7:0] b);
    exp_q.push_back(b);
    exp_csum = exp_csum ^ b;
  endtask

  task automatic exp_end();
`ifdef UART_FRAME_CHECKSUM_EN
    exp_q.push_back(exp_csum);
`endif
  endtask

  task automatic push(input logic [7:0] b, input logic l);
    byte_in       = b;
    last_in       = l;
    byte_valid_in = 1'b1;
    @(negedge clk_in);
    byte_valid_in = 1'b0;
    last_in       = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int c = 0;
    while ((exp_q.size() != 0 || tx_busy_in) && c < max_cyc) begin
      @(negedge clk_in);
      c++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    repeat (40) @(negedge clk_in);
  endtask

  // Monitor / scoreboard: compares every triggered byte against the queue.
  initial begin
    logic [7:0] held;
    logic       stable_chk;
    logic       prev_trig;
    held = 8'h00; stable_chk = 1'b0; prev_trig = 1'b0;
    forever begin
      @(negedge clk_in);
      if (!rst_in) begin
        stable_chk = 1'b0;
        prev_trig  = 1'b0;
      end else if (tx_trigger_out) begin
        n_trig++;
        check("trigger_single_cycle", {31'd0, prev_trig}, 32'd0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_trigger: got byte %02h, required no trigger", tx_byte_out);
        end else begin
          check("tx_byte", {24'd0, tx_byte_out}, {24'd0, exp_q.pop_front()});
        end
        held        = tx_byte_out;
        stable_chk  = 1'b1;
        idle_before = idle_run;
        idle_run    = 0;
        prev_trig   = 1'b1;
      end else begin
        prev_trig = 1'b0;
        if (stable_chk && tx_busy_in)
          check("tx_byte_stable", {24'd0, tx_byte_out}, {24'd0, held});
        if (!tx_busy_in) begin
          stable_chk = 1'b0;
          idle_run++;
        end else begin
          idle_run = 0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int c;
    int sent;
    bit conc;
    bit saw_full;
    logic [15:0] f0;
    logic [7:0]  b;

    // Reset state
    #3 rst_in = 1'b0;
    #1;
    check("rst_ready", {31'd0, ready_out}, 32'd1);
    check("rst_trigger", {31'd0, tx_trigger_out}, 32'd0);
    check("rst_tx_byte", {24'd0, tx_byte_out}, 32'd0);
    check("rst_overflow", {31'd0, overflow_out}, 32'd0);
    check("rst_frames", {16'd0, frames_sent_out}, 32'd0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);

    // Basic frame 01 02 03
    exp_header();
    exp_data(8'h01); exp_data(8'h02); exp_data(8'h03); exp_end();
    push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b1);
    wait_drain("basic", 2000);
    check("basic_frames", {16'd0, frames_sent_out}, 32'd1);

    // Mid-frame stall
    base = n_trig;
    exp_header(); exp_data(8'h10);
    push(8'h10, 1'b0);
    repeat (1000) @(negedge clk_in);
    check("stall_trigger_count", n_trig - base, 3);
    exp_data(8'h20); exp_end();
    push(8'h20, 1'b1);
    wait_drain("stall", 2000);
    check("stall_frames", {16'd0, frames_sent_out}, 32'd2);

    // Back-to-back one-byte frames, gap of 4
    f0 = frames_sent_out;
    base = n_trig;
    exp_header(); exp_data(8'h11); exp_end();
    exp_header(); exp_data(8'h22); exp_end();
    push(8'h11, 1'b1); push(8'h22, 1'b1);
`ifdef UART_FRAME_CHECKSUM_EN
    c = 0;
    while (n_trig < base + 5 && c < 2000) begin @(negedge clk_in); c++; end
`else
    c = 0;
    while (n_trig < base + 4 && c < 2000) begin @(negedge clk_in); c++; end
`endif
    check("b2b_idle_ge4", {31'd0, (idle_before >= 4)}, 32'd1);
    wait_drain("b2b", 2000);
    check("b2b_frames", {16'd0, frames_sent_out}, {16'd0, f0 + 16'd2});

    // Simultaneous push/pop while full during PAYLOAD
    do_reset();
    exp_header();
    sent = 0; conc = 1'b0; saw_full = 1'b0; c = 0;
    while (!conc && c < 5000) begin
      if (ready_out) begin
        b = sent[7:0];
        byte_in = b; last_in = 1'b0; byte_valid_in = 1'b1;
        exp_data(b);
        sent++;
      end else if (tx_trigger_out && saw_full) begin
        byte_in = 8'hC3; last_in = 1'b1; byte_valid_in = 1'b1;
        exp_data(8'hC3);
        conc = 1'b1;
      end else begin
        byte_valid_in = 1'b0;
      end
      if (!ready_out) saw_full = 1'b1;
      @(negedge clk_in);
      c++;
    end
    byte_valid_in = 1'b0; last_in = 1'b0;
    exp_end();
    check("full_concurrent_seen", {31'd0, conc}, 32'd1);
    check("full_after_push_pop", {31'd0, ready_out}, 32'd0);
    check("full_no_overflow", {31'd0, overflow_out}, 32'd0);
    wait_drain("full", 20000);
    check("full_overflow_end", {31'd0, overflow_out}, 32'd0);
    check("full_frames", {16'd0, frames_sent_out}, 32'd1);

    // Overflow: fill 512 while busy held, then push FF
    do_reset();
    hold_busy = 1'b1;
    for (int i = 0; i < 512; i++) begin
      if (i % 8 == 0) exp_header();
      b = 8'(i & 32'h7F);
      exp_data(b);
      if (i % 8 == 7) exp_end();
      push(b, (i % 8 == 7));
    end
    check("ovf_full_ready", {31'd0, ready_out}, 32'd0);
    check("ovf_before_drop", {31'd0, overflow_out}, 32'd0);
    push(8'hFF, 1'b1);
    check("ovf_set", {31'd0, overflow_out}, 32'd1);
    check("ovf_ready_low", {31'd0, ready_out}, 32'd0);
    hold_busy = 1'b0;
    wait_drain("ovf", 20000);
    check("ovf_sticky", {31'd0, overflow_out}, 32'd1);
    check("ovf_frames", {16'd0, frames_sent_out}, 32'd64);

    // Reset during the second payload byte
    base = n_trig;
    exp_header(); exp_data(8'h31); exp_data(8'h32);
    push(8'h31, 1'b0); push(8'h32, 1'b0); push(8'h33, 1'b1);
    c = 0;
    while (n_trig < base + 4 && c < 500) begin @(negedge clk_in); c++; end
    check("rst_mid_reached", n_trig - base, 4);
    #2 rst_in = 1'b0;
    #1;
    check("rst_mid_trigger", {31'd0, tx_trigger_out}, 32'd0);
    check("rst_mid_tx_byte", {24'd0, tx_byte_out}, 32'd0);
    check("rst_mid_ready", {31'd0, ready_out}, 32'd1);
    check("rst_mid_frames", {16'd0, frames_sent_out}, 32'd0);
    check("rst_mid_overflow", {31'd0, overflow_out}, 32'd0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (200) @(negedge clk_in);
    check("rst_mid_no_more_triggers", n_trig - base, 4);
    check("rst_mid_frames_after", {16'd0, frames_sent_out}, 32'd0);
    check("rst_mid_fifo_empty_ready", {31'd0, ready_out}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_streamer.md
UART_FRAME_STREAMER -- requirements
Module: uart_frame_streamer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 512: payload FIFO entries (power of two).
REQ-002 SHALL have parameter SYNC0, default 8'hA5: first header byte.
REQ-003 SHALL have parameter SYNC1, default 8'h5A: second header byte.
REQ-004 SHALL have parameter GAP_CYCLES, default 0: idle cycles inserted after each frame.
REQ-005 SHALL have port clk_in, input, 1: system clock (100 MHz).
REQ-006 SHALL have port rst_in, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port byte_in, input, 8: payload byte from the analysis pipeline.
REQ-008 SHALL have port byte_valid_in, input, 1: byte_in is valid this cycle.
REQ-009 SHALL have port last_in, input, 1: byte_in is the final byte of its frame; qualified by byte_valid_in.
REQ-010 SHALL have port ready_out, output, 1: FIFO not full.
REQ-011 SHALL have port tx_byte_out, output, 8: byte to uart_transmit data_byte_in.
REQ-012 SHALL have port tx_trigger_out, output, 1: one-cycle pulse to uart_transmit trigger_in.
REQ-013 SHALL have port tx_busy_in, input, 1: uart_transmit busy_out.
REQ-014 SHALL have port overflow_out, output, 1: sticky; a byte was dropped.
REQ-015 SHALL have port frames_sent_out, output, 16: count of completed frames.

Function
REQ-016 SHALL push {last_in, byte_in} into the FIFO on the cycle byte_valid_in=1 and the FIFO is not full.
REQ-017 SHALL drop byte_valid_in when the FIFO is full, set overflow_out=1, and leave FIFO contents unchanged.
REQ-018 SHALL drive ready_out = !full, combinational from the FIFO occupancy.
REQ-019 SHALL implement the FSM IDLE -> SYNC_A -> SYNC_B -> PAYLOAD -> [CSUM] -> GAP -> IDLE.
REQ-020 SHALL leave IDLE only when the FIFO is non-empty and tx_busy_in=0.
REQ-021 SHALL send each byte using the same per-byte handshake: pulse tx_trigger_out for one cycle with tx_byte_out stable; wait for tx_busy_in=1; then wait for tx_busy_in=0 before issuing the next trigger.
REQ-022 SHALL hold tx_byte_out stable from the trigger cycle until tx_busy_in falls.
REQ-023 SHALL send SYNC0 in SYNC_A and SYNC1 in SYNC_B.
REQ-024 SHALL, in PAYLOAD, pop one entry per transmitted byte.
REQ-025 SHALL leave PAYLOAD after transmitting an entry with last=1.
REQ-026 SHALL, if the FIFO is empty mid-frame, stall in PAYLOAD with no trigger until data arrives.
REQ-027 SHALL wait GAP_CYCLES cycles in GAP; with GAP_CYCLES=0, GAP lasts exactly one cycle.
REQ-028 SHALL increment frames_sent_out (modulo 2^16) on GAP entry.
REQ-029 SHALL allow a simultaneous push and pop in one cycle, including when the FIFO is full, with occupancy unchanged.
REQ-030 SHALL have FIFO read and write pointers wrap modulo FIFO_DEPTH.
REQ-031 SHALL issue its first trigger at most 2 cycles after the IDLE exit condition is met.

Reset
REQ-032 SHALL, while rst_in=0, asynchronously force FSM=IDLE, FIFO empty, ready_out=1, tx_trigger_out=0, tx_byte_out=0, overflow_out=0, frames_sent_out=0, and clear the checksum.
REQ-033 SHALL discard any partially sent frame on reset assertion, with no trigger issued after the release edge until REQ-020 holds.
REQ-034 SHALL be clear of overflow_out only by reset.

Configuration
REQ-035 SHALL, when UART_FRAME_CHECKSUM_EN is defined, accumulate an 8-bit XOR of all payload bytes of the frame.
REQ-036 SHALL, with UART_FRAME_CHECKSUM_EN defined, transmit the accumulated XOR in CSUM after the last payload byte and before GAP.
REQ-037 SHALL, with UART_FRAME_CHECKSUM_EN defined, clear the XOR accumulator on entry to SYNC_A.
REQ-038 SHALL, when UART_FRAME_CHECKSUM_EN is undefined, omit the CSUM state and accumulator, so that PAYLOAD goes directly to GAP.

Verification
REQ-039 SHALL verify the basic frame: push 3 bytes 0x01,0x02,0x03 (last on 0x03) with a UART model of busy=1 for 10 cycles -> tx sequence A5,5A,01,02,03, [00 with checksum]; frames_sent_out=1.
REQ-040 SHALL verify overflow: fill the FIFO with 512 entries while tx_busy_in is held at 1, then push 0xFF -> ready_out=0, overflow_out=1, 0xFF never transmitted.
REQ-041 SHALL verify the mid-frame stall: push 0x10, wait 1000 cycles, push 0x20 with last -> no trigger during the wait; tx sequence A5,5A,10,20.
REQ-042 SHALL verify back-to-back frames: two 1-byte frames 0x11 and 0x22 queued with GAP_CYCLES=4 -> ≥4 idle cycles between frames; frames_sent_out=2.
REQ-043 SHALL verify reset mid-frame: assert rst_in=0 during the second payload byte -> tx_trigger_out=0 immediately, FIFO empty, frames_sent_out=0.
REQ-044 SHALL verify simultaneous push/pop at full: FIFO full during PAYLOAD with concurrent push -> occupancy stays at FIFO_DEPTH, no drop, overflow_out=0.
